// File: rtl/config_pkg.sv
// Shared configuration, instruction format and helper types for the dispatcher.
package config_pkg;

  localparam int NumInstructions    = 29;
  localparam int NumVectorRegisters = 8;
  localparam int NumFus             = 4;

  typedef logic [$clog2(NumInstructions)-1:0]    pc_t;
  typedef logic [$clog2(NumVectorRegisters)-1:0] vreg_t;

  typedef enum logic [2:0] {
    FU_NOP        = 3'd0,
    FU_LOAD_STORE = 3'd1,
    FU_ROWWISE    = 3'd2,
    FU_TMATMUL    = 3'd3,
    FU_RMS        = 3'd4
  } fu_t;

  // op field is shared: LOAD_STORE uses LDV/SV, ROWWISE uses ADD..SIG
  localparam logic [2:0] OP_LDV = 3'd0;
  localparam logic [2:0] OP_SV  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_EXP = 3'd4;
  localparam logic [2:0] OP_SIG = 3'd5;

  typedef struct packed {
    fu_t        fu;
    logic [2:0] op;
    vreg_t      v_y;
    vreg_t      v_a;
    vreg_t      v_b;
  } instruction_t;

  typedef logic [NumFus-1:0]             fu_onehot_t;
  typedef logic [NumVectorRegisters-1:0] scoreboard_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic fu_onehot_t fu2onehot(fu_t fu);
    case (fu)
      FU_LOAD_STORE: return 4'b0001;
      FU_ROWWISE:    return 4'b0010;
      FU_TMATMUL:    return 4'b0100;
      FU_RMS:        return 4'b1000;
      default:       return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/instruction_dispatcher_scoreboard.sv
// Per-vector-register busy bits: clears from FU completions apply before the issue set.
module vreg_scoreboard
  import config_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  vreg_t                    set_addr_i,
  input  logic                     set_en_i,
  input  vreg_t [NumFus-1:0]       clr_addr_i,
  input  logic  [NumFus-1:0]       clr_en_i,
  input  vreg_t [2:0]              query_addr_i,
  output scoreboard_t              busy_o,
  output logic  [2:0]              hazard_o
);

  scoreboard_t busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NumFus; k++) begin
      if (clr_en_i[k]) busy_d[clr_addr_i[k]] = 1'b0;
    end
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // queries see registered state only, so a same-cycle clear still stalls once
  always_comb begin
    for (int i = 0; i < 3; i++) hazard_o[i] = busy_q[query_addr_i[i]];
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/instruction_dispatcher.sv
// In-order single-issue dispatcher: fetch, decode, hazard check and issue to four FUs.
//   state | meaning
//   IDLE  | waiting for start_i
//   FETCH | imem_addr_o=pc, capture ROM data into instr_q
//   ISSUE | hold instr until FU free and no RAW/WAW hazard, then handshake
//   DRAIN | last instruction issued, wait for all FUs and scoreboard to clear
//   DONE  | one-cycle done_o pulse
module instruction_dispatcher
  import config_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [$bits(pc_t)-1:0]       imem_addr_o,
  input  logic [$bits(instruction_t)-1:0] imem_data_i,
  output logic [$bits(instruction_t)-1:0] instr_o,
  output logic [NumFus-1:0]            fu_valid_o,
  input  logic [NumFus-1:0]            fu_ready_i,
  input  logic [NumFus-1:0]            fu_done_i
);

  localparam pc_t LastPc = pc_t'(NumInstructions - 1);

  state_t             state_q, state_d;
  pc_t                pc_q, pc_d;
  instruction_t       instr_q, instr_d;
  logic               error_q, error_d;
  fu_onehot_t         fu_out_q, fu_out_d;
  vreg_t [NumFus-1:0] tag_q, tag_d;
  logic  [NumFus-1:0] tag_vld_q, tag_vld_d;

  fu_onehot_t         fu_sel;
  logic [2:0]         fu_code;
  logic               illegal, uses_a, uses_b, uses_y;
  logic               can_issue, handshake, advance;
  logic               set_en;
  logic [NumFus-1:0]  clr_en;
  logic [2:0]         hazard;
  scoreboard_t        sb_busy;

  vreg_scoreboard u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .set_addr_i   (instr_q.v_y),
    .set_en_i     (set_en),
    .clr_addr_i   (tag_q),
    .clr_en_i     (clr_en),
    .query_addr_i ({instr_q.v_y, instr_q.v_b, instr_q.v_a}),
    .busy_o       (sb_busy),
    .hazard_o     (hazard)
  );

  always_comb begin
    fu_sel  = fu2onehot(instr_q.fu);
    fu_code = instr_q.fu;
    illegal = (fu_code > 3'd4);
    uses_a  = 1'b0;
    uses_b  = 1'b0;
    uses_y  = 1'b0;
    case (fu_sel)
      4'b0001: begin
        uses_a = (instr_q.op == OP_SV);
        uses_y = (instr_q.op != OP_SV);
      end
      4'b0010: begin
        uses_a = 1'b1;
        uses_b = (instr_q.op <= OP_DIV);
        uses_y = 1'b1;
      end
      4'b0100, 4'b1000: begin
        uses_a = 1'b1;
        uses_y = 1'b1;
      end
      default: ;
    endcase
  end

  assign can_issue = (fu_sel != '0) && ((fu_sel & fu_out_q) == '0) &&
                     !(uses_a && hazard[0]) && !(uses_b && hazard[1]) &&
                     !(uses_y && hazard[2]);
  assign fu_valid_o = (state_q == S_ISSUE && can_issue) ? fu_sel : '0;
  assign handshake  = |(fu_valid_o & fu_ready_i);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    error_d   = error_q;
    fu_out_d  = fu_out_q;
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    set_en    = 1'b0;
    clr_en    = '0;
    advance   = 1'b0;

    for (int k = 0; k < NumFus; k++) begin
      if (fu_done_i[k] && fu_out_q[k]) begin
        fu_out_d[k] = 1'b0;
        clr_en[k]   = tag_vld_q[k];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
          error_d = 1'b0;
        end
      end
      S_FETCH: begin
        instr_d = instruction_t'(imem_data_i);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (fu_sel == '0) begin
          if (illegal) error_d = 1'b1;
          advance = 1'b1;
        end else if (handshake) begin
          fu_out_d = fu_out_d | fu_sel;
          for (int k = 0; k < NumFus; k++) begin
            if (fu_sel[k]) begin
              tag_d[k]     = instr_q.v_y;
              tag_vld_d[k] = uses_y;
            end
          end
          set_en  = uses_y;
          advance = 1'b1;
        end
        if (advance) begin
          if (pc_q == LastPc) begin
            state_d = S_DRAIN;
          end else begin
            pc_d    = pc_q + pc_t'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (sb_busy == '0 && fu_out_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      error_q   <= 1'b0;
      fu_out_q  <= '0;
      tag_q     <= '0;
      tag_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      error_q   <= error_d;
      fu_out_q  <= fu_out_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign error_o     = error_q;
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Self-checking bench: cycle model of the program walk plus directed timing checks.
module tb_instruction_dispatcher;
  localparam int N = 29;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, error_o;
  logic [4:0]  imem_addr_o;
  logic [14:0] imem_data_i, instr_o;
  logic [3:0]  fu_valid_o;
  logic [3:0]  fu_ready_i = 4'b0;
  logic [3:0]  fu_done_i = 4'b0;

  always #5 clk_i = ~clk_i;

  logic [14:0] rom [N];
  assign imem_data_i = (int'(imem_addr_o) < N) ? rom[int'(imem_addr_o)] : 15'h0;

  instruction_dispatcher dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .instr_o(instr_o), .fu_valid_o(fu_valid_o),
    .fu_ready_i(fu_ready_i), .fu_done_i(fu_done_i)
  );

  int n_checks = 0, n_err = 0;
  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] mk(int fu, int op, int y, int a, int b);
    logic [2:0] f3, o3, y3, a3, b3;
    f3 = 3'(fu); o3 = 3'(op); y3 = 3'(y); a3 = 3'(a); b3 = 3'(b);
    return {f3, o3, y3, a3, b3};
  endfunction

  // operand usage straight from the instruction-set rules
  function automatic int fu_index(logic [14:0] i);
    int f = int'(i[14:12]);
    return (f >= 1 && f <= 4) ? f - 1 : -1;
  endfunction
  function automatic bit rd_a(logic [14:0] i);
    int f = int'(i[14:12]); int op = int'(i[11:9]);
    return (f == 1 && op == 1) || (f >= 2 && f <= 4);
  endfunction
  function automatic bit rd_b(logic [14:0] i);
    return int'(i[14:12]) == 2 && int'(i[11:9]) <= 3;
  endfunction
  function automatic bit wr_y(logic [14:0] i);
    int f = int'(i[14:12]); int op = int'(i[11:9]);
    return (f == 1 && op != 1) || (f >= 2 && f <= 4);
  endfunction

  // model: 0 idle, 1 fetch, 2 issue, 3 drain, 4 done
  int          m_mode = 0, m_pc = 0;
  logic [14:0] m_instr = 0;
  bit          m_err = 0;
  bit   [3:0]  m_out = 0;
  bit   [7:0]  m_busy = 0;
  int          m_tag [4];
  bit          m_tagv [4];

  function automatic bit can_issue_m(logic [14:0] i);
    int k = fu_index(i);
    if (k < 0) return 0;
    if (m_out[k]) return 0;
    if (rd_a(i) && m_busy[int'(i[5:3])]) return 0;
    if (rd_b(i) && m_busy[int'(i[2:0])]) return 0;
    if (wr_y(i) && m_busy[int'(i[8:6])]) return 0;
    return 1;
  endfunction

  bit rst_req = 1, start_req = 0, directed = 1, spur_en = 0, noise_start = 0;
  int fix_delay [4];
  int blk [4];
  int cnt [4];
  int cyc = 0, t_busy = 0, t_done = 0, t_last_fd = 0, done_cnt = 0;
  int t_fd [4];
  int t_vfirst [4];
  int hold_cnt = 0, hs3_cnt = 0, overlap_cnt = 0;
  bit prev_busy = 0;

  bit   [3:0] out_n;
  bit   [7:0] busy_n;
  logic [3:0] exp_v;
  int         km;
  bit         adv;

  always @(negedge clk_i) begin
    cyc++;
    km = fu_index(m_instr);
    exp_v = (m_mode == 2 && km >= 0 && can_issue_m(m_instr)) ? (4'b1 << km) : 4'b0;
    chk("busy_o", int'(busy_o), int'(m_mode != 0));
    chk("done_o", int'(done_o), int'(m_mode == 4));
    chk("imem_addr_o", int'(imem_addr_o), m_pc);
    chk("instr_o", int'(instr_o), int'(m_instr));
    chk("fu_valid_o", int'(fu_valid_o), int'(exp_v));
    chk("error_o", int'(error_o), int'(m_err));

    if (busy_o && !prev_busy) t_busy = cyc;
    prev_busy = busy_o;
    if (done_o) begin done_cnt++; t_done = cyc; end
    for (int k = 0; k < 4; k++) if (fu_valid_o[k] && t_vfirst[k] < 0) t_vfirst[k] = cyc;
    if (cnt[1] > 0 && cnt[2] > 0) overlap_cnt++;

    rst_i   = rst_req;
    start_i = start_req || (noise_start && m_mode != 0 && $urandom_range(0, 7) == 0);
    start_req = 0;
    for (int k = 0; k < 4; k++) begin
      if (cnt[k] > 0) begin
        fu_done_i[k] = (cnt[k] == 1);
        if (cnt[k] == 1) begin t_fd[k] = cyc; t_last_fd = cyc; end
        cnt[k]--;
      end else begin
        fu_done_i[k] = spur_en && ($urandom_range(0, 15) == 0);
      end
      if (directed) begin
        fu_ready_i[k] = (blk[k] == 0);
        if (fu_valid_o[k] && blk[k] > 0) blk[k]--;
      end else begin
        fu_ready_i[k] = ($urandom_range(0, 2) != 0);
      end
      if (fu_valid_o[k] && fu_ready_i[k]) begin
        cnt[k] = directed ? fix_delay[k] : int'($urandom_range(1, 8));
        if (k == 3) hs3_cnt++;
      end
      if (rst_i) cnt[k] = 0;
    end
    if (fu_valid_o == 4'b1000 && !fu_ready_i[3]) hold_cnt++;

    if (rst_i) begin
      m_mode = 0; m_pc = 0; m_instr = 0; m_err = 0; m_out = 0; m_busy = 0;
      for (int k = 0; k < 4; k++) begin m_tag[k] = 0; m_tagv[k] = 0; end
    end else begin
      out_n = m_out; busy_n = m_busy;
      for (int k = 0; k < 4; k++) begin
        if (fu_done_i[k] && m_out[k]) begin
          out_n[k] = 0;
          if (m_tagv[k]) busy_n[m_tag[k]] = 0;
        end
      end
      case (m_mode)
        0: if (start_i) begin m_mode = 1; m_pc = 0; m_err = 0; end
        1: begin m_instr = rom[m_pc]; m_mode = 2; end
        2: begin
          adv = 0;
          if (km < 0) begin
            if (int'(m_instr[14:12]) >= 5) m_err = 1;
            adv = 1;
          end else if (can_issue_m(m_instr) && fu_ready_i[km]) begin
            out_n[km] = 1;
            m_tag[km] = int'(m_instr[8:6]);
            m_tagv[km] = wr_y(m_instr);
            if (wr_y(m_instr)) busy_n[int'(m_instr[8:6])] = 1;
            adv = 1;
          end
          if (adv) begin
            if (m_pc == N - 1) m_mode = 3;
            else begin m_pc++; m_mode = 1; end
          end
        end
        3: if (m_out == 0 && m_busy == 0) m_mode = 4;
        default: m_mode = 0;
      endcase
      m_out = out_n; m_busy = busy_n;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < N; i++) rom[i] = 15'h0;
  endtask

  task automatic clear_marks();
    for (int k = 0; k < 4; k++) begin t_vfirst[k] = -1; t_fd[k] = -1; end
  endtask

  task automatic run_prog(int budget);
    int d0 = done_cnt;
    bit got = 0;
    start_req = 1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i);
      if (done_cnt > d0) begin got = 1; break; end
    end
    chk("program_completes", int'(got), 1);
    repeat (2) @(posedge clk_i);
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int d;
    clear_rom();
    clear_marks();
    for (int k = 0; k < 4; k++) begin fix_delay[k] = 1; blk[k] = 0; cnt[k] = 0; end

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_valid", int'(fu_valid_o), 0);
    chk("rst_addr", int'(imem_addr_o), 0);
    chk("rst_instr", int'(instr_o), 0);
    chk("rst_error", int'(error_o), 0);
    @(posedge clk_i);
    rst_req = 0;
    repeat (3) @(posedge clk_i);

    // 29 NOPs: two cycles per instruction, one drain cycle, then done
    run_prog(300);
    chk("nop_latency", t_done - t_busy, 59);
    chk("nop_error", int'(error_o), 0);

    // RAW on v3
    clear_rom(); clear_marks();
    rom[0] = mk(1, 0, 3, 0, 0);
    rom[1] = mk(3, 0, 5, 3, 0);
    fix_delay[0] = 10;
    run_prog(300);
    chk("raw_issue_after_done", t_vfirst[2] - t_fd[0], 1);

    // handshake hold, then v2 kept busy until RMS completes
    clear_rom(); clear_marks();
    rom[0] = mk(4, 0, 2, 1, 0);
    rom[1] = mk(2, 0, 3, 2, 0);
    fix_delay[3] = 6; blk[3] = 5; hold_cnt = 0; hs3_cnt = 0;
    run_prog(300);
    chk("hold_cycles", hold_cnt, 5);
    chk("rms_issues", hs3_cnt, 1);
    chk("busy_v2_stall", t_vfirst[1] - t_fd[3], 1);

    // parallel FUs at the tail, drain waits for the later completion
    clear_rom(); clear_marks();
    rom[27] = mk(2, 0, 2, 0, 1);
    rom[28] = mk(3, 0, 6, 4, 0);
    fix_delay[1] = 20; fix_delay[2] = 5; overlap_cnt = 0;
    run_prog(300);
    chk("parallel_overlap", int'(overlap_cnt > 0), 1);
    chk("drain_latency", t_done - t_last_fd, 2);
    chk("later_is_rowwise", int'(t_fd[1] > t_fd[2]), 1);

    // illegal fu code at pc 4
    clear_rom(); clear_marks();
    rom[4] = mk(7, 0, 0, 0, 0);
    run_prog(300);
    #1;
    chk("error_sticky", int'(error_o), 1);

    // reset while draining a long load
    clear_rom(); clear_marks();
    rom[28] = mk(1, 0, 7, 0, 0);
    fix_delay[0] = 40;
    start_req = 1;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i);
      if (m_mode == 3) begin got = 1; break; end
    end
    chk("reached_drain", int'(got), 1);
    chk("error_cleared_by_start", int'(error_o), 0);
    repeat (3) @(posedge clk_i);
    d = done_cnt;
    rst_req = 1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_drain_idle", int'(busy_o), 0);
    rst_req = 0;
    repeat (60) @(posedge clk_i);
    chk("rst_drain_no_done", done_cnt - d, 0);

    // scoreboard cleared: reading v7 issues right away
    clear_rom(); clear_marks();
    rom[0] = mk(3, 0, 0, 7, 0);
    for (int k = 0; k < 4; k++) fix_delay[k] = 1;
    run_prog(300);
    chk("sb_clear_issue", t_vfirst[2] - t_busy, 1);

    // random programs with random FU behaviour and stray start/done pulses
    directed = 0; spur_en = 1; noise_start = 1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        rom[i] = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
      run_prog(3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_dispatcher.md
Name: instruction_dispatcher

Overview:
- In-order, single-issue controller that runs the program in instruction memory.
- Fetches one instruction_t per program-counter step and decodes its fu field.
- Issues the instruction to one of four functional units (LOAD_STORE, ROWWISE_OPERATION, TMATMUL, RMS) over a valid/ready handshake.
- Keeps a per-vector-register scoreboard and stalls on register hazards.
- Sits between the program ROM and the FU datapaths; top-level control sees only start/busy/done.

Parameters:
- NumInstructions, config_pkg::NumInstructions (29): program length; pc runs 0..NumInstructions-1.
- NumVectorRegisters, config_pkg::NumVectorRegisters (8): scoreboard depth.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start program; sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the program has fully retired.
- error_o  out  1  sticky; set on an illegal fu encoding; cleared by reset or start_i.
- imem_addr_o  out  $bits(pc_t)  instruction ROM address.
- imem_data_i  in  $bits(instruction_t)  ROM data, valid 1 cycle after address.
- instr_o  out  $bits(instruction_t)  registered instruction, broadcast to all FUs.
- fu_valid_o  out  4  issue valid, one-hot. Bit 0 LOAD_STORE, 1 ROWWISE_OPERATION, 2 TMATMUL, 3 RMS.
- fu_ready_i  in  4  FU accepts an issue.
- fu_done_i  in  4  one-cycle completion pulse per FU.

Behaviour:
- Reset:
  - State IDLE; pc=0.
  - Scoreboard cleared; fu_outstanding cleared.
  - All outputs 0, including instr_o and error_o.
  - Reset mid-program abandons all in-flight state; FUs are reset by the same rst_i.
- FSM:
  - IDLE: on start_i → FETCH with pc=0; error_o cleared.
  - FETCH: drive imem_addr_o=pc. Next cycle, register imem_data_i into instr_o → ISSUE.
  - ISSUE: decode; hold until the instruction can issue (rules below). On handshake, or immediately for NOP:
    - if pc==NumInstructions-1 → DRAIN;
    - else pc+=1 → FETCH.
  - DRAIN: wait until the scoreboard and fu_outstanding are all zero → DONE.
  - DONE: done_o=1 for one cycle → IDLE.
- Throughput: 2 cycles per instruction minimum, no prefetch. imem_addr_o holds pc in every state.
- Operand usage per fu:
  - LOAD_STORE LDV: writes v_y. LOAD_STORE SV: reads v_a.
  - ROWWISE_OPERATION: reads v_a; reads v_b only for ADD, SUB, MUL, DIV (not EXP, SIG); writes v_y.
  - TMATMUL and RMS: read v_a, write v_y.
  - NOP: uses nothing and retires in ISSUE in 1 cycle.
  - fu encodings 5..7: treated as NOP and set error_o.
- Issue condition (all evaluated on registered state):
  - fu_outstanding[k]==0 — at most one in-flight instruction per FU;
  - no used source register is busy (RAW);
  - the destination register is not busy (WAW).
- Issue output:
  - fu_valid_o[k] is asserted only while the condition holds. Once asserted it stays high, with instr_o stable, until fu_ready_i[k].
  - The handshake occurs on the cycle where valid&ready.
- Handshake effects:
  - set fu_outstanding[k];
  - store v_y in a per-FU tag register, or a "no dest" flag for SV;
  - set busy[v_y] if a destination is used.
- Completion: fu_done_i[k] with fu_outstanding[k] set clears fu_outstanding[k] and busy[tag_k]. fu_done_i on an idle FU is ignored.
- Simultaneous completion and issue on the same cycle:
  - clear applied first, then set, so re-issuing the same v_y keeps it busy;
  - the issue check still uses pre-clear state, costing one stall cycle; this is intended.
- start_i outside IDLE is ignored.

Decomposition:
- config_pkg additions:
  - fu_onehot_t, a 4-bit type;
  - function fu2onehot(fu_t), which returns 0 for NOP and illegal codes;
  - scoreboard_t, a logic [NumVectorRegisters-1:0] type.
- One sub-module: vreg_scoreboard.
  - Inputs: set port (addr, en) and four clear ports.
  - Outputs: busy vector and hazard queries for 3 addresses.
- FSM, pc and per-FU tags stay in instruction_dispatcher.

Test Plan:
- Reset/idle: rst_i=1 for 2 cycles with start_i=0 → busy_o=0, done_o=0, fu_valid_o=0, imem_addr_o=0.
- Straight-line program:
  - stimulus: ROM of 29 NOPs, start_i pulse;
  - response: imem_addr_o steps 0..28, each address held 2 cycles; done_o pulses exactly once; error_o=0.
- RAW stall:
  - stimulus: instr0 LDV v_y=3; instr1 TMATMUL v_a=3 v_y=5; LOAD_STORE done 10 cycles after accept;
  - response: fu_valid_o[2] stays low until the cycle after fu_done_i[0]; then instr1 issues.
- Handshake hold:
  - stimulus: RMS v_a=1 v_y=2 with fu_ready_i[3]=0 for 5 cycles;
  - response: fu_valid_o=4'b1000 and instr_o stable for all 5 cycles; one issue recorded; busy[2] set afterwards.
- Parallel FUs and drain:
  - stimulus: ROWWISE ADD v_a=0 v_b=1 v_y=2, then TMATMUL v_a=4 v_y=6 as the last instruction;
  - response: both in flight together; done_o waits for the later of the two fu_done_i pulses.
- Illegal fu and reset mid-program:
  - stimulus: fu=3'b111 at pc 4;
  - response: error_o=1, pc advances.
  - stimulus: rst_i asserted while in DRAIN;
  - response: IDLE next cycle, scoreboard zero, no done_o.
